piso_tx: RTL and testbench
==========================

Name: piso_tx

Overview:
- Parallel-in serial-out transmitter: accepts a WIDTH-bit parallel word over a valid/ready handshake and shifts it out one bit per clock.
- Companion to the team's parallel registers: sits on the serial side of a PIPO-fed datapath and drives a single-wire serial link toward a SIPO receiver.
- Bit-counter FSM with framing strobes (first/last bit) and support for back-to-back words with no gap.

Parameters:
- WIDTH, 4, data word width in bits (min 2).
- MSB_FIRST, 1, 1 = transmit bit WIDTH-1 first; 0 = transmit bit 0 first.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- d  input  WIDTH  parallel data word; sampled only on handshake.
- load_valid  input  1  upstream has a word on d.
- load_ready  output  1  transmitter can accept a word this cycle.
- sout  output  1  serial data bit.
- sout_valid  output  1  sout carries a valid bit this cycle.
- first  output  1  high with the first bit of each word.
- last  output  1  high with the final bit of each word (final data bit, or parity bit when enabled).
- busy  output  1  high whenever a frame is being transmitted.

Behaviour:
- Reset (reset=0, async): state=IDLE; shift register, bit counter, sout, sout_valid, first, last and busy all 0. load_ready goes to 1 once reset is released. Any frame in flight is discarded with no partial completion. Release is synchronous to clk.
- States: IDLE and SHIFT. PARITY is present only under the optional feature.
- Handshake:
  - A word is accepted at a rising edge when load_valid=1 and load_ready=1.
  - load_ready is combinational from registered state: 1 in IDLE, and 1 in the cycle where last=1.
  - load_ready is 0 elsewhere; load_valid is ignored while it is 0.
  - d must be stable only on the accept edge.
- Latency: the first bit is registered onto sout in the cycle after acceptance (1-cycle latency).
- Bit order: each bit is held exactly one cycle. MSB_FIRST=1 sends d[WIDTH-1] down to d[0]; MSB_FIRST=0 sends d[0] up to d[WIDTH-1].
- SHIFT state:
  - sout_valid=1 and busy=1.
  - Bit counter runs 0..WIDTH-1 and must be wide enough for WIDTH.
  - first=1 when counter=0.
  - last=1 when counter=WIDTH-1 (without the parity feature).
- After the last bit:
  - If a new word is accepted in that cycle: stay in SHIFT, reset counter=0, load the new word. The next cycle carries the first bit of the new word with first=1, so there is no idle gap.
  - Otherwise: go to IDLE. sout_valid, busy and sout return to 0.
- IDLE: sout=0, sout_valid=0, first=0, last=0, busy=0.
- Simultaneous reset and handshake: reset wins and the word is not accepted.
- sout is don't-care to the receiver when sout_valid=0, but must still be driven to 0.

Optional Feature:
- Macro: PISO_PARITY_EN.
- Defined:
  - After the WIDTH data bits, one extra cycle in state PARITY sends even parity (XOR of all WIDTH data bits) with sout_valid=1 and last=1.
  - last is not asserted on the final data bit.
  - load_ready is high during the PARITY cycle instead of the final data bit cycle.
  - Frame length is WIDTH+1 cycles.
- Undefined: no PARITY state, frame length is WIDTH cycles, and the behaviour above applies unchanged.

Test Plan:
- Single word, WIDTH=4, MSB_FIRST=1: reset low 2 cycles then high; load d=4'b1011 -> sout 1,0,1,1 on the 4 cycles after accept; first on bit 1; last on bit 4; then sout_valid=0 and busy=0.
- Back-to-back: load_valid held, d=4'b1001 then 4'b1110 (second accepted on the last-bit cycle) -> 8 contiguous valid bits 1,0,0,1,1,1,1,0; first pulses at bits 1 and 5; last pulses at bits 4 and 8; no gap.
- LSB first, MSB_FIRST=0: load 4'b0111 -> sout 1,1,1,0.
- Backpressure: load_valid=1 with d=4'b1111 presented at bit 2 of a 4'b0011 frame -> load_ready=0 and the word is not taken until the last-bit cycle; 4'b0011 serializes unchanged.
- Reset mid-frame: assert reset during bit 2 of 4'b1011 -> all outputs 0 immediately (async), load_ready=1 after release, and the next load of 4'b0111 transmits cleanly.
- With PISO_PARITY_EN: load 4'b1011 -> sout 1,0,1,1,1 (parity=1); last only on the 5th bit. Load 4'b1001 -> parity bit 0.

Source files
------------

// File: rtl/piso_tx.sv
// Purpose: parallel-in serial-out transmitter, one WIDTH-bit word per frame, one bit per clock.
// Latency: first bit appears on sout the cycle after the accept edge; back-to-back words leave no gap.
// Backpressure: load_ready is high only when idle or on the final cycle of a frame; load_valid is ignored otherwise.
// Optional feature: define PISO_PARITY_EN to append an even-parity bit as the final cycle of every frame.
module piso_tx #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             first,
    output logic             last,
    output logic             busy
);

    // Counter must be able to represent WIDTH, so size it for WIDTH+1 values.
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

`ifdef PISO_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
    typedef enum logic [0:0] {IDLE, SHIFT} state_t;
`endif

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_shifted;
    logic [CW-1:0]    cnt;
    logic             cur_bit;
    logic             at_end;
    logic             accept;
    logic             ready_int;
`ifdef PISO_PARITY_EN
    logic             par;
`endif

    // The outgoing bit always sits at one end of the shift register.
    assign cur_bit       = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
    assign shreg_shifted = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
    assign at_end        = (cnt == CNT_LAST);
    assign accept        = load_valid & load_ready;

    // State register; reset drops any frame in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and frame outputs, all derived from registered state.
    always_comb begin
        state_nxt  = state;
        ready_int  = 1'b0;
        sout       = 1'b0;
        sout_valid = 1'b0;
        first      = 1'b0;
        last       = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                ready_int = 1'b1;
            end
            SHIFT: begin
                sout       = cur_bit;
                sout_valid = 1'b1;
                busy       = 1'b1;
                first      = (cnt == '0);
`ifdef PISO_PARITY_EN
                if (at_end) begin
                    state_nxt = PARITY;
                end
`else
                last      = at_end;
                ready_int = at_end;
                if (at_end) begin
                    state_nxt = IDLE;
                end
`endif
            end
`ifdef PISO_PARITY_EN
            PARITY: begin
                sout       = par;
                sout_valid = 1'b1;
                busy       = 1'b1;
                last       = 1'b1;
                ready_int  = 1'b1;
                state_nxt  = IDLE;
            end
`endif
            default: begin
                state_nxt = IDLE;
            end
        endcase
        // Holding reset low blocks the handshake so a word cannot slip in under reset.
        load_ready = ready_int & reset;
        // A word accepted on the idle or final cycle always starts a fresh frame next cycle.
        if (load_valid && load_ready) begin
            state_nxt = SHIFT;
        end
    end

    // Datapath: load on accept, otherwise shift and count while in SHIFT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg <= '0;
            cnt   <= '0;
`ifdef PISO_PARITY_EN
            par   <= 1'b0;
`endif
        end else if (accept) begin
            shreg <= d;
            cnt   <= '0;
`ifdef PISO_PARITY_EN
            par   <= ^d;
`endif
        end else if (state == SHIFT) begin
            shreg <= shreg_shifted;
            cnt   <= at_end ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: tb/tb_piso_tx.sv
// Scoreboarded bench for piso_tx: lane 0 is MSB-first, lane 1 is LSB-first.
// The driver issues words; the monitor pushes the expected frame on each observed
// handshake and pops/compares one entry per valid serial bit.
module tb_piso_tx;
    localparam int W = 4;
`ifdef PISO_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    typedef struct packed {
        logic b;
        logic f;
        logic l;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [1:0]   vld;
    logic [W-1:0] dd [2];
    logic [1:0]   rdy, so, sov, fst, lst, bsy;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    generate
        for (genvar g = 0; g < 2; g++) begin : lane
            localparam bit MSBF = (g == 0);
            exp_t q[$];

            piso_tx #(.WIDTH(W), .MSB_FIRST(MSBF)) dut (
                .clk        (clk),
                .reset      (reset),
                .d          (dd[g]),
                .load_valid (vld[g]),
                .load_ready (rdy[g]),
                .sout       (so[g]),
                .sout_valid (sov[g]),
                .first      (fst[g]),
                .last       (lst[g]),
                .busy       (bsy[g])
            );

            // Monitor: check the presented bit, then record any handshake seen this cycle.
            always @(negedge clk) begin
                exp_t e;
                if (!reset) begin
                    q.delete();
                    chk($sformatf("rst_sout_valid[%0d]", g), 32'(sov[g]), 0);
                    chk($sformatf("rst_busy[%0d]", g), 32'(bsy[g]), 0);
                    chk($sformatf("rst_sout[%0d]", g), 32'(so[g]), 0);
                    chk($sformatf("rst_first_last[%0d]", g), 32'({fst[g], lst[g]}), 0);
                    chk($sformatf("rst_ready[%0d]", g), 32'(rdy[g]), 0);
                end else begin
                    if (sov[g]) begin
                        if (q.size() == 0) begin
                            chk($sformatf("unexpected_bit[%0d]", g), 1, 0);
                        end else begin
                            e = q.pop_front();
                            chk($sformatf("sout[%0d]", g), 32'(so[g]), 32'(e.b));
                            chk($sformatf("first[%0d]", g), 32'(fst[g]), 32'(e.f));
                            chk($sformatf("last[%0d]", g), 32'(lst[g]), 32'(e.l));
                            chk($sformatf("busy[%0d]", g), 32'(bsy[g]), 1);
                        end
                    end else begin
                        chk($sformatf("missing_bits[%0d]", g), 32'(q.size()), 0);
                        q.delete();
                        chk($sformatf("idle_outs[%0d]", g), 32'({so[g], fst[g], lst[g], bsy[g]}), 0);
                    end
                    // Ready whenever nothing beyond the bit just shown remains in the frame.
                    chk($sformatf("load_ready[%0d]", g), 32'(rdy[g]), 32'(q.size() == 0));
                    if (vld[g] && rdy[g]) begin
                        for (int i = 0; i < W; i++) begin
                            e.b = MSBF ? dd[g][W-1-i] : dd[g][i];
                            e.f = (i == 0);
                            e.l = (i == W - 1) && !PAR;
                            q.push_back(e);
                        end
                        if (PAR) begin
                            e.b = ^dd[g];
                            e.f = 1'b0;
                            e.l = 1'b1;
                            q.push_back(e);
                        end
                    end
                end
            end
        end
    endgenerate

    // Present a word and hold it until the handshake completes (bounded wait).
    task automatic send(input int k, input logic [W-1:0] w);
        vld[k] = 1'b1;
        dd[k]  = w;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (rdy[k]) begin
                @(posedge clk);
                #2;
                vld[k] = 1'b0;
                return;
            end
        end
        tests++;
        fails++;
        $display("FAIL send_timeout lane %0d word %0d", k, w);
        vld[k] = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vld   = 2'b00;
        dd[0] = '0;
        dd[1] = '0;
        reset = 1'b0;
        idle_cycles(2);
        reset = 1'b1;
        #1 chk("ready_after_reset", 32'(rdy[0]), 1);

        // Single word, MSB first.
        send(0, 4'b1011);
        idle_cycles(7);

        // Back-to-back words with no gap.
        send(0, 4'b1001);
        send(0, 4'b1110);
        idle_cycles(7);

        // LSB first.
        send(1, 4'b0111);
        idle_cycles(7);

        // Backpressure: a new word offered mid-frame must wait for the final cycle.
        send(0, 4'b0011);
        vld[0] = 1'b1;
        dd[0]  = 4'b1111;
        #1 chk("bp_ready_low", 32'(rdy[0]), 0);
        send(0, 4'b1111);
        idle_cycles(7);

        // Reset in the middle of a frame clears outputs immediately.
        send(0, 4'b1011);
        idle_cycles(1);
        reset = 1'b0;
        #1;
        chk("async_sout_valid", 32'(sov[0]), 0);
        chk("async_busy", 32'(bsy[0]), 0);
        chk("async_first_last", 32'({fst[0], lst[0]}), 0);
        chk("async_sout", 32'(so[0]), 0);
        idle_cycles(2);
        reset = 1'b1;
        #1 chk("ready_after_midreset", 32'(rdy[0]), 1);
        send(0, 4'b0111);
        idle_cycles(7);

        // Randomized traffic on both lanes with occasional resets.
        for (int i = 0; i < 600; i++) begin
            @(posedge clk);
            #2;
            if ($urandom_range(0, 149) == 0) begin
                reset = 1'b0;
            end else begin
                reset = 1'b1;
            end
            for (int k = 0; k < 2; k++) begin
                vld[k] = 1'($urandom_range(0, 3) != 0);
                dd[k]  = W'($urandom);
            end
        end
        reset = 1'b1;
        vld   = 2'b00;
        idle_cycles(12);
        chk("drain_lane0", 32'(lane[0].q.size()), 0);
        chk("drain_lane1", 32'(lane[1].q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
